// File: rtl/sensor_scan_ctrl.sv
// rtl/sensor_scan_ctrl.sv - time-multiplexed sensor bank scanner with per-bank consecutive-error alarm
//
// Steps bank_sel across NUM_BANKS sensor banks (two cycles per bank: SETTLE, then SAMPLE),
// evaluates each 4-bit sensor word with the error rule, and raises a held alarm once a bank
// produces ERR_THRESH consecutive erroring samples. The alarm holds until alarm_ack.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   enable      level, 1 = keep scanning
//   sensors     sensor word of the currently selected bank (mux output)
//   alarm_ack   acknowledge from the fault handler, only honoured in ALARM
//   bank_sel    bank mux select
//   error_now   error result of the most recent sample
//   alarm       high while in ALARM
//   alarm_bank  bank that raised the alarm
//   scan_done   one-cycle pulse when the last bank is sampled without alarm
//   busy        high in any state other than IDLE
module sensor_scan_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int ERR_THRESH = 3,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic [3:0]    sensors,
    input  logic          alarm_ack,
    output logic [BW-1:0] bank_sel,
    output logic          error_now,
    output logic          alarm,
    output logic [BW-1:0] alarm_bank,
    output logic          scan_done,
    output logic          busy
);

    localparam int            CW     = $clog2(ERR_THRESH + 1);
    localparam logic [CW-1:0] THRESH = CW'(ERR_THRESH);
    localparam logic [BW-1:0] LAST   = BW'(NUM_BANKS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ALARM} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt [NUM_BANKS];
    logic [BW-1:0] r_bank_sel;
    logic [BW-1:0] r_alarm_bank;
    logic          r_error_now;
    logic          r_alarm;
    logic          r_scan_done;
    logic          r_busy;

    logic          w_err;
    logic [CW-1:0] w_cnt_cur;
    logic [CW-1:0] w_cnt_upd;
    logic [BW-1:0] w_bank_nxt;

    assign w_err      = sensors[0] | (sensors[1] & sensors[2]) | (sensors[1] & sensors[3]);
    assign w_cnt_cur  = r_cnt[r_bank_sel];
    // Saturating consecutive-error count; any clean sample restarts the run.
    assign w_cnt_upd  = !w_err                ? '0 :
                        (w_cnt_cur == THRESH) ? w_cnt_cur :
                                                w_cnt_cur + CW'(1);
    assign w_bank_nxt = (r_bank_sel == LAST) ? '0 : r_bank_sel + BW'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_bank_sel   <= '0;
            r_alarm_bank <= '0;
            r_error_now  <= 1'b0;
            r_alarm      <= 1'b0;
            r_scan_done  <= 1'b0;
            r_busy       <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= SETTLE;
                        r_busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_error_now         <= w_err;
                    r_cnt[r_bank_sel]   <= w_cnt_upd;
                    if (w_cnt_upd == THRESH) begin
                        // bank_sel stays on the offending bank while alarmed
                        r_state      <= ALARM;
                        r_alarm      <= 1'b1;
                        r_alarm_bank <= r_bank_sel;
                    end else begin
                        r_bank_sel  <= w_bank_nxt;
                        r_scan_done <= (r_bank_sel == LAST);
                        r_state     <= enable ? SETTLE : IDLE;
                        r_busy      <= enable;
                    end
                end
                ALARM: begin
                    // enable is deliberately ignored until the handler acknowledges
                    if (alarm_ack) begin
                        r_alarm             <= 1'b0;
                        r_cnt[r_alarm_bank] <= '0;
                        r_bank_sel          <= w_bank_nxt;
                        r_state             <= enable ? SETTLE : IDLE;
                        r_busy              <= enable;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bank_sel   = r_bank_sel;
    assign error_now  = r_error_now;
    assign alarm      = r_alarm;
    assign alarm_bank = r_alarm_bank;
    assign scan_done  = r_scan_done;
    assign busy       = r_busy;

endmodule

// File: doc/sensor_scan_ctrl.md
Name: sensor_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-bit sensor error check. It steps a bank-select mux across NUM_BANKS sensor banks and samples each bank's 4-bit sensor word. Each sample is evaluated with the team's sensor error rule. A per-bank count of consecutive errors raises a held alarm that must be acknowledged. The block sits between the sensor bank mux and the system fault handler.

Parameters:
NUM_BANKS, 4, number of sensor banks scanned (2..16)
ERR_THRESH, 3, consecutive erroring samples of one bank that raise the alarm (1..15)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable  input  1  level; 1 = keep scanning
sensors  input  4  sensor word from the currently selected bank (mux output)
alarm_ack  input  1  fault handler acknowledge; sampled only in ALARM
bank_sel  output  max(1,$clog2(NUM_BANKS))  drives the sensor bank mux
error_now  output  1  registered error result of the most recent sample
alarm  output  1  held high while in ALARM
alarm_bank  output  same as bank_sel  bank that raised the alarm
scan_done  output  1  one-cycle pulse when bank NUM_BANKS-1 is sampled without alarm
busy  output  1  1 in any state other than IDLE

Behaviour:
- Clocking and reset: one clock (clk); asynchronous active-low reset (n_rst). All outputs and state are registered.
- Reset values: state=IDLE, bank_sel=0, error_now=0, alarm=0, alarm_bank=0, scan_done=0, busy=0, all per-bank counters=0.
- Error rule, evaluated on the sampled sensors: err = s[0] | (s[1]&s[2]) | (s[1]&s[3]).
- Counters: one per bank, width $clog2(ERR_THRESH+1).
  - err=1 increments the counter, saturating at ERR_THRESH.
  - err=0 clears the counter to 0.
- FSM states: IDLE, SETTLE, SAMPLE, ALARM.
- IDLE: enable=1 moves to SETTLE next cycle. bank_sel holds its value, so a new scan resumes at the next unscanned bank.
- SETTLE: one cycle of mux settling with bank_sel stable. Always moves to SAMPLE.
- SAMPLE:
  - Capture sensors; error_now <= err; update counter[bank_sel].
  - If the updated counter == ERR_THRESH: go to ALARM, set alarm <= 1 and alarm_bank <= bank_sel. bank_sel does not advance.
  - Otherwise: bank_sel <= bank_sel+1, wrapping NUM_BANKS-1 to 0. scan_done pulses if the bank just sampled was NUM_BANKS-1. Go to SETTLE if enable=1, else IDLE.
- ALARM:
  - alarm stays 1 and bank_sel stays frozen.
  - enable is ignored until the alarm is acknowledged.
  - alarm_ack=1: next cycle alarm=0, counter[alarm_bank] cleared, bank_sel advances with wrap. Go to SETTLE if enable=1, else IDLE. scan_done is not pulsed on this exit.
- Latency: 2 cycles per bank, 2*NUM_BANKS cycles per clean full scan. The alarm rises on the clock edge ending the offending SAMPLE cycle.
- Boundary rules:
  - alarm_ack outside ALARM is ignored, including when it coincides with the SAMPLE cycle that raises the alarm.
  - enable dropping during SETTLE or SAMPLE lets the current bank finish its sample, then the FSM goes to IDLE.
  - A counter at saturation never wraps.
  - ERR_THRESH=1 alarms on the first erroring sample.
  - sensors is ignored outside SAMPLE.
  - n_rst asserted in any state, including mid-ALARM, clears everything immediately. After release the FSM restarts at bank 0 with all counters zero.

Test Plan:
1. n_rst=0 mid-scan, then released -> bank_sel=0, alarm=0, busy=0, scan_done=0, and the first post-reset sample is bank 0.
2. enable=1, all banks sensors=4'b0000 -> bank_sel sequence 0,0,1,1,2,2,3,3,0…; scan_done pulses every 8 cycles; alarm stays 0; error_now=0.
3. Bank 2 drives 4'b0110, others 4'b0000 -> alarm=1 and alarm_bank=2 after the 3rd scan's bank-2 SAMPLE; bank_sel stays 2 until ack; alarm_ack=1 for one cycle -> alarm=0, bank_sel=3; bank 2 then needs 3 more erroring samples to re-alarm.
4. Bank 1 sequence across scans: 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001 -> no alarm after scan 2 (counter cleared in scan 3); alarm after scan 6.
5. Single-bank error-rule checks:
   - 4'b1010 -> error_now=1 (s1&s3)
   - 4'b1100 -> error_now=0
   - 4'b0100 -> error_now=0
   - 4'b0011 -> error_now=1
6. In ALARM, alarm_ack held 0 for 20 cycles with enable toggling -> alarm stays 1 and bank_sel is frozen. Then n_rst pulse -> alarm=0, counters zero, no alarm until 3 new erroring samples.
